cpld_uart_responder: RTL and testbench
======================================

CPLD_UART_RESPONDER -- requirements
Module: cpld_uart_responder

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 uart_wrn  input  1  host write strobe, active low, synchronous to clk.
REQ-006 uart_rdn  input  1  host read strobe, active low, synchronous to clk.
REQ-007 data_in  input  8  shared data bus value (low byte) as seen by the responder.
REQ-008 data_out  output  8  byte driven onto the shared bus during a read.
REQ-009 data_oe  output  1  bus drive enable for data_out.
REQ-010 uart_dataready  output  1  received byte available.
REQ-011 uart_tbre  output  1  transmit holding register empty.
REQ-012 uart_tsre  output  1  transmit shifter empty, line idle.
REQ-013 txd  output  1  serial transmit line, idle high.
REQ-014 rxd  input  1  serial receive line, asynchronous to clk.

Function
REQ-015 SHALL use DIV = CLK_FREQ/BAUD (integer division) clocks per bit; DIV < 4 is unsupported.
REQ-016 SHALL detect a write as uart_wrn 1 in the previous cycle and 0 in the current cycle. With tbre=1, data_in SHALL be latched into the holding register and tbre SHALL read 0 from the next cycle.
REQ-017 A write with tbre=0 SHALL be dropped, with no state change.
REQ-018 The TX FSM SHALL have states T_IDLE, T_START, T_DATA, T_STOP.
  - Holding register full while in T_IDLE: load shifter, tbre=1 and tsre=0 next cycle, enter T_START.
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly DIV cycles on txd.
REQ-019 At the end of T_STOP:
  - holding register full: go directly to T_START, with no idle bit.
  - otherwise: go to T_IDLE and set tsre=1.
REQ-020 A write landing in the same cycle the shifter loads SHALL be accepted into the now-empty holding register only from the following cycle (tbre timing governs).
REQ-021 SHALL pass rxd through a two-flop synchronizer; only the synchronized value is used.
REQ-022 The RX FSM SHALL have states R_IDLE, R_START, R_DATA, R_STOP.
  - Falling edge of synchronized rxd in R_IDLE: enter R_START and wait DIV/2 cycles.
  - Sample reads 1 (false start): return to R_IDLE.
  - Otherwise: sample 8 data bits at DIV intervals, LSB first, then the stop bit.
REQ-023 Stop bit 1 SHALL write the byte into rx_buf and set uart_dataready=1 the next cycle; an unread previous byte is overwritten.
REQ-024 Stop bit 0 (framing error) SHALL discard the byte, leave rx_buf and dataready unchanged, and return to R_IDLE after rxd is high.
REQ-025 While uart_rdn=0: data_oe=1 and data_out=rx_buf (combinational from registered state). Otherwise data_oe=0.
REQ-026 The rising edge of uart_rdn (0->1) SHALL clear uart_dataready.
REQ-027 If a new byte completes in the same cycle as that rising edge, the new byte SHALL win: dataready stays 1 and rx_buf holds the new byte.
REQ-028 Read and write paths SHALL operate independently; simultaneous low rdn/wrn are both serviced.

Reset
REQ-029 On rst_n=0 (asynchronous) SHALL force:
  - txd=1, tbre=1, tsre=1, dataready=0, data_oe=0, data_out=0;
  - both FSMs to idle, bit/baud counters 0, holding/shift/rx_buf 0.
REQ-030 Reset mid-frame SHALL abort the frame immediately, with txd high within the reset assertion; a partially received byte is discarded.
REQ-031 After rst_n deasserts, the first wrn falling edge SHALL be detected only if wrn was sampled high for at least one cycle after release.

Verification (CLK_FREQ=8, BAUD=1, DIV=8)
REQ-032 Write 0xA5 -> tbre 0 for 1 cycle, then 1; tsre 0; txd = 0,1,0,1,0,0,1,0,1,1 (8 cycles each); tsre=1 after 80 cycles.
REQ-033 Back-to-back writes 0x01 then 0xFF while tbre=1 -> second frame starts the cycle after the first stop bit ends; a third write with tbre=0 is dropped.
REQ-034 Drive rxd frame for 0x3C -> dataready=1; rdn low gives data_oe=1 and data_out=0x3C; dataready=0 after rdn rises.
REQ-035 rxd low 3 cycles then high -> no byte, dataready stays 0. Frame 0x55 with stop bit 0 -> rx_buf unchanged.
REQ-036 Second frame 0x77 completes on the exact cycle rdn rises -> dataready stays 1 and data_out reads 0x77 on the next read.
REQ-037 rst_n pulsed low mid-TX at bit 4 -> txd=1, tbre=1, tsre=1 immediately; a new write afterwards produces a clean full frame.

Source files
------------

// File: rtl/cpld_uart_responder.sv
// cpld_uart_responder: byte-wide host port in front of a fixed 8N1 UART.
// The host writes a byte with a uart_wrn falling edge and reads the last
// received byte while uart_rdn is low; status flags report TX/RX progress.
//
// Host strobe semantics: a write is the single cycle where uart_wrn was 1
// last cycle and is 0 now; it is taken only when uart_tbre=1, otherwise it
// is ignored. A read presents rx_buf on data_out for every cycle uart_rdn
// is 0, and the 0->1 edge of uart_rdn acknowledges (clears) uart_dataready.
module cpld_uart_responder #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_wrn,
    input  logic       uart_rdn,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       uart_dataready,
    output logic       uart_tbre,
    output logic       uart_tsre,
    output logic       txd,
    input  logic       rxd,
    output logic [1:0] tx_state,
    output logic [1:0] rx_state
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    tx_state_t     tx_cur, tx_nxt;
    rx_state_t     rx_cur, rx_nxt;

    logic          wrn_prev;
    logic [7:0]    hold_reg;
    logic [7:0]    tx_shift;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bits;
    logic          tx_bit_end;
    logic          wr_edge;
    logic          tx_load;

    logic          rx_s1, rx_s2, rx_prev;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_buf;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bits;
    logic          frame_err;
    logic          rx_done;
    logic          rdn_prev;
    logic          rd_rise;
    logic          active;

    assign wr_edge    = wrn_prev & ~uart_wrn;
    assign tx_bit_end = (tx_cnt == BIT_LAST);
    assign rd_rise    = ~rdn_prev & uart_rdn;
    assign tx_state   = tx_cur;
    assign rx_state   = rx_cur;

    // TX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_cur <= T_IDLE;
        else        tx_cur <= tx_nxt;
    end

    // TX next state: a full holding register (tbre=0) starts or chains a frame
    always_comb begin
        tx_nxt = tx_cur;
        case (tx_cur)
            T_IDLE:  if (!uart_tbre) tx_nxt = T_START;
            T_START: if (tx_bit_end) tx_nxt = T_DATA;
            T_DATA:  if (tx_bit_end && tx_bits == 3'd7) tx_nxt = T_STOP;
            T_STOP:  if (tx_bit_end) tx_nxt = uart_tbre ? T_IDLE : T_START;
            default: tx_nxt = T_IDLE;
        endcase
    end

    // TX outputs: line level per state, and the shifter-load strobe
    always_comb begin
        txd     = 1'b1;
        tx_load = 1'b0;
        case (tx_cur)
            T_START: txd = 1'b0;
            T_DATA:  txd = tx_shift[0];
            default: txd = 1'b1;
        endcase
        if (!uart_tbre && (tx_cur == T_IDLE || (tx_cur == T_STOP && tx_bit_end)))
            tx_load = 1'b1;
    end

    // TX datapath: host write capture, shifter, baud and bit counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrn_prev  <= 1'b0;
            hold_reg  <= 8'h00;
            tx_shift  <= 8'h00;
            tx_cnt    <= '0;
            tx_bits   <= 3'd0;
            uart_tbre <= 1'b1;
            uart_tsre <= 1'b1;
        end else begin
            wrn_prev <= uart_wrn;
            // tx_load needs tbre=0 and capture needs tbre=1, so they never collide
            if (wr_edge && uart_tbre) begin
                hold_reg  <= data_in;
                uart_tbre <= 1'b0;
            end
            if (tx_load) begin
                tx_shift  <= hold_reg;
                uart_tbre <= 1'b1;
                uart_tsre <= 1'b0;
            end else if (tx_cur == T_STOP && tx_bit_end) begin
                uart_tsre <= 1'b1;
            end
            if (tx_cur == T_IDLE || tx_bit_end) tx_cnt <= '0;
            else                                tx_cnt <= tx_cnt + 1'b1;
            if (tx_cur == T_DATA && tx_bit_end) begin
                if (!tx_load) tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bits <= tx_bits + 3'd1;
            end
        end
    end

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_cur <= R_IDLE;
        else        rx_cur <= rx_nxt;
    end

    // RX next state: start edge, mid-start check, data bits, stop bit
    always_comb begin
        rx_nxt = rx_cur;
        case (rx_cur)
            R_IDLE:  if (rx_prev && !rx_s2) rx_nxt = R_START;
            R_START: if (rx_cnt == HALF_LAST) rx_nxt = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (rx_cnt == BIT_LAST && rx_bits == 3'd7) rx_nxt = R_STOP;
            R_STOP:  if (rx_cnt == BIT_LAST && rx_s2) rx_nxt = R_IDLE;
            default: rx_nxt = R_IDLE;
        endcase
    end

    // RX outputs: good-stop strobe and host bus drive
    always_comb begin
        rx_done  = (rx_cur == R_STOP) && (rx_cnt == BIT_LAST) && rx_s2 && !frame_err;
        data_oe  = active & ~uart_rdn;
        data_out = data_oe ? rx_buf : 8'h00;
    end

    // RX datapath: synchronizer, counters, deserializer, buffer and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1          <= 1'b1;
            rx_s2          <= 1'b1;
            rx_prev        <= 1'b1;
            rx_shift       <= 8'h00;
            rx_buf         <= 8'h00;
            rx_cnt         <= '0;
            rx_bits        <= 3'd0;
            frame_err      <= 1'b0;
            rdn_prev       <= 1'b1;
            uart_dataready <= 1'b0;
            active         <= 1'b0;
        end else begin
            active   <= 1'b1;
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rdn_prev <= uart_rdn;
            case (rx_cur)
                R_IDLE: begin
                    rx_cnt    <= '0;
                    rx_bits   <= 3'd0;
                    frame_err <= 1'b0;
                end
                R_START: rx_cnt <= (rx_cnt == HALF_LAST) ? '0 : rx_cnt + 1'b1;
                R_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bits  <= rx_bits + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    // a low stop bit parks here until the line returns high
                    if (rx_cnt != BIT_LAST) rx_cnt <= rx_cnt + 1'b1;
                    else if (!rx_s2)        frame_err <= 1'b1;
                end
                default: rx_cnt <= '0;
            endcase
            if (rx_done) rx_buf <= rx_shift;
            // a byte landing on the acknowledge edge takes priority
            if (rx_done)      uart_dataready <= 1'b1;
            else if (rd_rise) uart_dataready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpld_uart_responder.sv
// Bench for cpld_uart_responder at DIV=8: directed host/serial stimulus,
// with expected TX bytes and host-read bytes queued for two monitors.
module tb_cpld_uart_responder;

  localparam int CLK_FREQ = 8;
  localparam int BAUD     = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_wrn = 1'b0;
  logic       uart_rdn = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rxd = 1'b1;
  logic [7:0] data_out;
  logic       data_oe;
  logic       uart_dataready;
  logic       uart_tbre;
  logic       uart_tsre;
  logic       txd;
  logic [1:0] tx_state;
  logic [1:0] rx_state;

  int total = 0;
  int bad = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rd_exp_q[$];
  logic [9:0] a5_frame = 10'b1101001010;

  cpld_uart_responder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .uart_wrn(uart_wrn), .uart_rdn(uart_rdn),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .uart_dataready(uart_dataready), .uart_tbre(uart_tbre),
    .uart_tsre(uart_tsre), .txd(txd), .rxd(rxd),
    .tx_state(tx_state), .rx_state(rx_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic host_write(input logic [7:0] b);
    @(negedge clk); uart_wrn = 1'b0; data_in = b;
    @(negedge clk); uart_wrn = 1'b1;
  endtask

  task automatic host_read();
    @(negedge clk); uart_rdn = 1'b0;
    @(negedge clk); uart_rdn = 1'b1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      rxd = f[j];
      repeat (8) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic wait_tsre(input string name);
    int n;
    n = 0;
    while (!uart_tsre && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, uart_tsre, 1'b1);
  endtask

  // TX monitor: decodes txd frames mid-bit and compares with tx_exp_q
  logic       mon_busy = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_cap = 8'h00;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (txd == 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 4) begin
        check("tx_start_bit", txd, 1'b0);
      end else if (mon_cnt > 4 && mon_cnt <= 68 && (mon_cnt - 4) % 8 == 0) begin
        mon_cap = {txd, mon_cap[7:1]};
      end else if (mon_cnt == 76) begin
        check("tx_stop_bit", txd, 1'b1);
        if (tx_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: got %0h expected none", mon_cap);
        end else begin
          check("tx_byte", mon_cap, tx_exp_q.pop_front());
        end
        mon_busy = 1'b0;
      end
    end
  end

  // read monitor: on the first driven cycle of each read compare data_out
  logic oe_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (data_oe && !oe_prev) begin
      if (rd_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got %0h expected none", data_out);
      end else begin
        check("rd_data", data_out, rd_exp_q.pop_front());
      end
    end
    oe_prev = data_oe;
  end

  initial begin
    // reset state, with rdn and wrn held low throughout reset
    repeat (3) @(posedge clk); #1;
    check("rst_txd", txd, 1'b1);
    check("rst_tbre", uart_tbre, 1'b1);
    check("rst_tsre", uart_tsre, 1'b1);
    check("rst_dataready", uart_dataready, 1'b0);
    check("rst_data_oe", data_oe, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    @(negedge clk); uart_rdn = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("no_write_wrn_low_from_reset", uart_tbre, 1'b1);
    check("no_frame_wrn_low_from_reset", uart_tsre, 1'b1);
    @(negedge clk); uart_wrn = 1'b1;
    repeat (2) @(negedge clk);

    // single write 0xA5 with cycle-exact line check
    @(negedge clk); uart_wrn = 1'b0; data_in = 8'hA5; tx_exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    check("a5_tbre_low", uart_tbre, 1'b0);
    @(negedge clk); uart_wrn = 1'b1;
    @(posedge clk); #1;
    check("a5_tbre_back", uart_tbre, 1'b1);
    check("a5_tsre_busy", uart_tsre, 1'b0);
    for (int i = 0; i < 80; i++) begin
      check("a5_txd", txd, a5_frame[i / 8]);
      if (i == 79) check("a5_tsre_last", uart_tsre, 1'b0);
      @(posedge clk); #1;
    end
    check("a5_tsre_done", uart_tsre, 1'b1);
    repeat (4) @(negedge clk);

    // back-to-back 0x01 then 0xFF, third write 0x99 dropped
    @(negedge clk); uart_wrn = 1'b0; data_in = 8'h01; tx_exp_q.push_back(8'h01);
    @(negedge clk); uart_wrn = 1'b1;
    @(negedge clk); uart_wrn = 1'b0; data_in = 8'hFF; tx_exp_q.push_back(8'hFF);
    @(negedge clk); uart_wrn = 1'b1;
    @(negedge clk); uart_wrn = 1'b0; data_in = 8'h99;
    @(negedge clk); uart_wrn = 1'b1;
    @(posedge clk); #1;
    check("b2b_hold_full", uart_tbre, 1'b0);
    repeat (75) @(posedge clk); #1;
    check("b2b_stop_level", txd, 1'b1);
    @(posedge clk); #1;
    check("b2b_second_start", txd, 1'b0);
    check("b2b_tbre_reload", uart_tbre, 1'b1);
    check("b2b_tsre_busy", uart_tsre, 1'b0);
    begin
      int n;
      n = 0;
      while (!uart_tsre && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      check("b2b_second_len", n, 80);
    end
    repeat (20) @(posedge clk);

    // receive 0x3C and read it back
    send_rx(8'h3C, 1'b1);
    @(posedge clk); #1;
    check("rx3c_dataready", uart_dataready, 1'b1);
    rd_exp_q.push_back(8'h3C);
    @(negedge clk); uart_rdn = 1'b0;
    @(posedge clk); #1;
    check("rx3c_data_oe", data_oe, 1'b1);
    @(negedge clk); uart_rdn = 1'b1;
    @(posedge clk); #1;
    check("rx3c_dataready_clr", uart_dataready, 1'b0);
    check("rx3c_data_oe_off", data_oe, 1'b0);

    // false start: 3 low cycles
    @(negedge clk); rxd = 1'b0;
    repeat (3) @(negedge clk); rxd = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("false_start_dataready", uart_dataready, 1'b0);
    check("false_start_rx_idle", rx_state, 2'd0);

    // framing error on 0x55: buffer keeps 0x3C
    send_rx(8'h55, 1'b0);
    repeat (4) @(posedge clk); #1;
    check("frame_err_dataready", uart_dataready, 1'b0);
    check("frame_err_rx_idle", rx_state, 2'd0);
    rd_exp_q.push_back(8'h3C);
    host_read();

    // 0x12 pending, then 0x77 completes on the rdn rising edge
    send_rx(8'h12, 1'b1);
    @(posedge clk); #1;
    check("rx12_dataready", uart_dataready, 1'b1);
    rd_exp_q.push_back(8'h12);
    fork
      send_rx(8'h77, 1'b1);
      begin
        repeat (78) @(negedge clk);
        uart_rdn = 1'b0;
        @(negedge clk);
        uart_rdn = 1'b1;
      end
    join
    @(posedge clk); #1;
    check("new_byte_wins_dataready", uart_dataready, 1'b1);

    // simultaneous read of 0x77 and write of 0x81
    rd_exp_q.push_back(8'h77);
    tx_exp_q.push_back(8'h81);
    @(negedge clk); uart_rdn = 1'b0; uart_wrn = 1'b0; data_in = 8'h81;
    @(negedge clk); uart_rdn = 1'b1; uart_wrn = 1'b1;
    @(posedge clk); #1;
    check("simul_dataready_clr", uart_dataready, 1'b0);
    check("simul_tsre_busy", uart_tsre, 1'b0);
    wait_tsre("simul_tx_done");
    repeat (4) @(negedge clk);

    // reset during data bit 4 of 0xC3, then a clean 0x5A frame
    @(negedge clk); uart_wrn = 1'b0; data_in = 8'hC3; tx_exp_q.push_back(8'hC3);
    @(posedge clk); #1;
    @(negedge clk); uart_wrn = 1'b1;
    repeat (43) @(posedge clk); #1;
    check("c3_bit4_level", txd, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    tx_exp_q.delete();
    #1;
    check("midrst_txd", txd, 1'b1);
    check("midrst_tbre", uart_tbre, 1'b1);
    check("midrst_tsre", uart_tsre, 1'b1);
    check("midrst_tx_idle", tx_state, 2'd0);
    repeat (2) @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tx_exp_q.push_back(8'h5A);
    host_write(8'h5A);
    @(posedge clk); #1;
    check("post_rst_tsre_busy", uart_tsre, 1'b0);
    wait_tsre("post_rst_tx_done");
    repeat (10) @(posedge clk); #1;
    check("tx_queue_empty", tx_exp_q.size(), 0);
    check("rd_queue_empty", rd_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
